dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised data memory for the xgriscv core with a valid/ready request and response
//  handshake, sized little-endian loads and stores, sign or zero extension, and a
//  configurable read latency.
//  It sits between the MEM stage and the byte-addressed data RAM.
//  Misaligned and out-of-range accesses are reported as errors rather than silently wrapped.
// PARAMETERS
//  XLEN         32    data and address width; only 32 is supported
//  DEPTH_BYTES  4096  RAM size in bytes; must be a power of two and a multiple of 4
//  LATENCY      1     cycles from request acceptance to rsp_valid; must be >= 1
// PORTS
//  clk           in   1     clock; all state updates on its rising edge
//  rstn          in   1     asynchronous active-low reset
//  req_valid     in   1     request present
//  req_ready     out  1     block can accept a request (high only in IDLE)
//  req_we        in   1     1 = store, 0 = load
//  req_size      in   2     00 = byte, 01 = half, 10 = word, 11 = illegal
//  req_unsigned  in   1     load only: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   XLEN  byte address
//  req_wdata     in   XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1     response present; held until rsp_ready
//  rsp_ready     in   1     consumer accepts the response
//  rsp_rdata     out  XLEN  extended load data; 0 for stores and for errors
//  rsp_err       out  1     misaligned, out-of-range or illegal-size access
// BEHAVIOUR
//  Reset (rstn low, asynchronous):
//   - state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
//   - RAM contents are not cleared.
//   - Any in-flight request is discarded without a response; a store already committed stays committed.
//  FSM:
//   - req_ready = (state == IDLE), so req_ready is 1 during and immediately after reset.
//   - IDLE -> WAIT when req_valid && req_ready and LATENCY > 1; the counter loads LATENCY-1.
//   - IDLE -> RESP when req_valid && req_ready and LATENCY == 1.
//   - WAIT: decrement the counter each cycle; -> RESP when it reaches 1.
//   - RESP: rsp_valid = 1; -> IDLE on rsp_ready. rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
//   - Maximum throughput is one request per LATENCY+1 cycles when rsp_ready is held high.
//  Acceptance edge (the edge where req_valid && req_ready):
//   - The error check is done, the store is written, and the load data is captured into the response register.
//   - A later store cannot affect a captured load.
//  Error conditions (rsp_err = 1, RAM not written, rsp_rdata = 0):
//   - size 11;
//   - size 01 with addr[0] = 1;
//   - size 10 with addr[1:0] != 0;
//   - addr + bytes - 1 >= DEPTH_BYTES.
//  Data layout and extension:
//   - Little-endian: byte k of the access sits at RAM[addr+k].
//   - A store writes only 1, 2 or 4 bytes; the other bytes are preserved.
//   - Byte load: sign-extends bit 7 unless req_unsigned.
//   - Half load: sign-extends bit 15 unless req_unsigned.
//   - Word load: req_unsigned is ignored.
//  Stores return a response with rdata = 0 and err = 0.
//  Request inputs are ignored outside IDLE; the requester must hold them until accepted.
// TESTING
//  1. LATENCY=1: word store 0xDEADBEEF at 0x10, then word load at 0x10
//     -> rsp_valid one cycle after acceptance; rdata = 0xDEADBEEF, err = 0.
//  2. Byte load at 0x13 of that word, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
//     Half load at 0x10, signed -> 0xFFFFBEEF.
//  3. Half store 0x1234 at 0x12, then word load at 0x10
//     -> 0x1234BEEF (lower half preserved).
//  4. Word load at 0x11, half store at 0x13, and word access at 0xFFC+4
//     -> each returns err = 1, rdata = 0; a reload of 0x10 shows RAM unchanged.
//  5. LATENCY=3 with rsp_ready held low for 5 cycles
//     -> rsp_valid rises 3 cycles after acceptance; data stable; req_ready = 0 until the rsp handshake.
//  6. rstn pulsed low in WAIT
//     -> rsp_valid = 0 immediately, req_ready = 1, no response is produced; earlier stores remain in RAM.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data RAM for the xgriscv MEM stage.
// Valid/ready request and response handshakes, little-endian sized loads and
// stores with sign/zero extension, error reporting for misaligned and
// out-of-range accesses, and a configurable request-to-response latency.
module dmem_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic [2:0]      nbytes;
    logic [XLEN:0]   last_byte;
    logic            acc_err;
    logic [AW-1:0]   a0, a1, a2, a3;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_data_p0;
    logic [XLEN-1:0] rdata_p1;
    logic            err_p1;

    // Right-align and extend the raw little-endian bytes for the access size.
    function automatic logic [XLEN-1:0] extend_load(input logic [1:0]      size,
                                                    input logic            uns,
                                                    input logic [XLEN-1:0] data);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = data[7:0];
        h = data[15:0];
        case (size)
            2'b00:   extend_load = {{(XLEN-8){b[7] & ~uns}}, data[7:0]};
            2'b01:   extend_load = {{(XLEN-16){h[15] & ~uns}}, data[15:0]};
            default: extend_load = data;
        endcase
    endfunction

    assign accept    = req_valid && req_ready;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_p1;
    assign rsp_err   = err_p1;

    // Stage p0: decode the request, check it and fetch the addressed bytes.
    always_comb begin
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        // One extra bit so an address near the top of the space cannot wrap into range.
        last_byte = {1'b0, req_addr} + (XLEN+1)'(nbytes) - (XLEN+1)'(1);
        acc_err   = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || (last_byte >= (XLEN+1)'(DEPTH_BYTES));
        a0  = req_addr[AW-1:0];
        a1  = a0 + AW'(1);
        a2  = a0 + AW'(2);
        a3  = a0 + AW'(3);
        raw = {mem[a3], mem[a2], mem[a1], mem[a0]};
        ld_data_p0 = (req_we || acc_err) ? '0 : extend_load(req_size, req_unsigned, raw);
    end

    // Commit a legal store on its acceptance edge; only the addressed bytes change.
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            mem[a0] <= req_wdata[7:0];
            if (req_size != 2'b00) begin
                mem[a1] <= req_wdata[15:8];
            end
            if (req_size == 2'b10) begin
                mem[a2] <= req_wdata[23:16];
                mem[a3] <= req_wdata[31:24];
            end
        end
    end

    // Stage p1: response register, captured on acceptance and held until consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            rdata_p1 <= ld_data_p0;
            err_p1   <= acc_err;
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts out the latency, RESP holds until rsp_ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a LATENCY=1 and a LATENCY=3 instance.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        v1, v3, rr1, rr3;
    logic        rdy1, rdy3, rv1, rv3, er1, er3;
    logic [31:0] rd1, rd3;

    int          sel;
    logic        m_rdy, m_rv, m_er;
    logic [31:0] m_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.XLEN(32), .DEPTH_BYTES(4096), .LATENCY(1)) u1 (
        .clk(clk), .rstn(rstn),
        .req_valid(v1), .req_ready(rdy1), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(er1)
    );

    dmem_ctrl #(.XLEN(32), .DEPTH_BYTES(4096), .LATENCY(3)) u3 (
        .clk(clk), .rstn(rstn),
        .req_valid(v3), .req_ready(rdy3), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rd3), .rsp_err(er3)
    );

    always_comb begin
        if (sel == 1) begin
            m_rdy = rdy1; m_rv = rv1; m_er = er1; m_rd = rd1;
        end else begin
            m_rdy = rdy3; m_rv = rv3; m_er = er3; m_rd = rd3;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance u (1 or 3) with rsp_ready held high.
    task automatic xact(input int u, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        sel = u;
        req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
        if (u == 1) begin v1 = 1'b1; rr1 = 1'b1; end
        else        begin v3 = 1'b1; rr3 = 1'b1; end
        #1;
        chk($sformatf("u%0d req_ready idle", u), 32'(m_rdy), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0; v3 = 1'b0;
        lat = 1;
        while (!m_rv && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("u%0d req_ready busy", u), 32'(m_rdy), 32'd0);
        rd = m_rd;
        er = m_er;
        @(posedge clk); #1;
        chk($sformatf("u%0d rsp_valid after handshake", u), 32'(m_rv), 32'd0);
        chk($sformatf("u%0d req_ready after handshake", u), 32'(m_rdy), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'hAAAA_1234, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_BEEF, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0013, 32'h0000_5555, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_BEEF, 1'b0};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0102_0304, 32'h0000_0000, 1'b0};
        tbl[14] = '{1'b0, 2'd2, 1'b1, 32'h0000_0FFC, 32'h0,         32'h0102_0304, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0001, 1'b0};
        tbl[16] = '{1'b0, 2'd1, 1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0000, 1'b1};
        tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0000_0102, 1'b0};
        tbl[18] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        tbl[19] = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1};
        tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'hFFFF_FF7A, 32'h0000_0000, 1'b0};
        tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_7AEF, 1'b0};
        tbl[22] = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_007A, 1'b0};
        tbl[23] = '{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};

        sel = 1;
        v1 = 1'b0; v3 = 1'b0; rr1 = 1'b0; rr3 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = '0; req_wdata = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("reset u1 req_ready", 32'(rdy1), 32'd1);
        chk("reset u1 rsp_valid", 32'(rv1),  32'd0);
        chk("reset u1 rsp_rdata", rd1,       32'd0);
        chk("reset u1 rsp_err",   32'(er1),  32'd0);
        chk("reset u3 req_ready", 32'(rdy3), 32'd1);
        chk("reset u3 rsp_valid", 32'(rv3),  32'd0);
        chk("reset u3 rsp_rdata", rd3,       32'd0);
        chk("reset u3 rsp_err",   32'(er3),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Table of single transactions on the LATENCY=1 instance.
        for (int i = 0; i < 24; i++) begin
            xact(1, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
        end

        // LATENCY=3: store, then a load held off by rsp_ready low for 5 cycles.
        xact(3, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, rd, er, lat);
        chk("l3 store latency", 32'(lat), 32'd3);
        chk("l3 store rdata", rd, 32'd0);
        chk("l3 store err", 32'(er), 32'd0);

        @(negedge clk);
        sel = 3;
        req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h40; req_wdata = '0;
        v3 = 1'b1; rr3 = 1'b0;
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("l3 req_ready in wait", 32'(rdy3), 32'd0);
        lat = 1;
        while (!rv3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l3 load latency", 32'(lat), 32'd3);
        // A store presented while busy must be ignored and must not touch the captured data.
        req_we = 1'b1; req_wdata = 32'h0; v3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("l3 hold%0d rsp_valid", k), 32'(rv3), 32'd1);
            chk($sformatf("l3 hold%0d rdata", k), rd3, 32'h1122_3344);
            chk($sformatf("l3 hold%0d err", k), 32'(er3), 32'd0);
            chk($sformatf("l3 hold%0d req_ready", k), 32'(rdy3), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        v3 = 1'b0; rr3 = 1'b1;
        @(posedge clk); #1;
        chk("l3 released rsp_valid", 32'(rv3), 32'd0);
        chk("l3 released req_ready", 32'(rdy3), 32'd1);
        xact(3, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("l3 reload rdata", rd, 32'h1122_3344);
        chk("l3 reload latency", 32'(lat), 32'd3);

        // Reset pulsed while a load waits: no response, RAM kept.
        xact(3, 1'b1, 2'd2, 1'b0, 32'h44, 32'hA5A5_A5A5, rd, er, lat);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h44;
        v3 = 1'b1; rr3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("rst-wait in wait", 32'(rdy3), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("rst-wait rsp_valid", 32'(rv3), 32'd0);
        chk("rst-wait req_ready", 32'(rdy3), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rv3) seen++;
        end
        chk("rst-wait no response", 32'(seen), 32'd0);
        xact(3, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, rd, er, lat);
        chk("rst-wait ram 0x44", rd, 32'hA5A5_A5A5);
        xact(3, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("rst-wait ram 0x40", rd, 32'h1122_3344);
        xact(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("rst u1 ram 0x10", rd, 32'h1234_7AEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
